// File: rtl/bp_fe_icache_trace_buffer.sv
// bp_fe_icache_trace_buffer
// Synthesizable I$ event tracer. It watches channels_p I$ instances and records
// one timestamped event per cycle into a circular buffer. The buffer is drained
// through a valid/yumi handshake. It also keeps saturating per-channel/per-op
// event counters and a counter of lost records.
// Optional build macro: BP_FE_ICACHE_TRACE_FILTER_EN adds an inclusive paddr
// window (filt_lo_i..filt_hi_i) that limits which events are recorded.

module bp_fe_icache_trace_buffer_chk (
    input logic clk_i,
    input logic reset_n_i,
    input logic rec_v_i,
    input logic rec_yumi_i
);
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        rec_yumi_i |-> rec_v_i);
endmodule

module bp_fe_icache_trace_buffer #(
    parameter int channels_p    = 2,
    parameter int paddr_width_p = 40,
    parameter int depth_p       = 16,
    parameter int ts_width_p    = 32,
    parameter int cnt_width_p   = 32
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  en_i,
    input  logic                                  overwrite_i,
    input  logic [channels_p-1:0]                 access_v_i,
    input  logic [channels_p-1:0]                 fetch_v_i,
    input  logic [channels_p-1:0]                 spec_v_i,
    input  logic [channels_p-1:0]                 req_v_i,
    input  logic [channels_p*paddr_width_p-1:0]   paddr_i,
`ifdef BP_FE_ICACHE_TRACE_FILTER_EN
    input  logic [paddr_width_p-1:0]              filt_lo_i,
    input  logic [paddr_width_p-1:0]              filt_hi_i,
`endif
    output logic [ts_width_p+5+paddr_width_p-1:0] rec_o,
    output logic                                  rec_v_o,
    input  logic                                  rec_yumi_i,
    input  logic [$clog2(4*channels_p)-1:0]       cnt_sel_i,
    output logic [cnt_width_p-1:0]                cnt_o,
    output logic [cnt_width_p-1:0]                drop_cnt_o,
    output logic                                  full_o
);
    localparam int rec_width_lp  = ts_width_p + 5 + paddr_width_p;
    localparam int num_cnt_lp    = 4 * channels_p;
    localparam int ch_width_lp   = (channels_p > 1) ? $clog2(channels_p) : 1;
    localparam int addr_width_lp = $clog2(depth_p);

    typedef enum logic [1:0] {
        OP_ACCESS = 2'd0,
        OP_FETCH  = 2'd1,
        OP_SPEC   = 2'd2,
        OP_REQ    = 2'd3
    } op_e;

    // Add a small increment to a counter, clamping at all-ones (cnt_width_p >= 8).
    function automatic logic [cnt_width_p-1:0] sat_add(input logic [cnt_width_p-1:0] a,
                                                       input logic [7:0] b);
        logic [cnt_width_p:0] sum;
        sum = {1'b0, a} + {{(cnt_width_p-7){1'b0}}, b};
        sat_add = sum[cnt_width_p] ? {cnt_width_p{1'b1}} : sum[cnt_width_p-1:0];
    endfunction

    logic [ts_width_p-1:0]    ts_r;
    logic [ch_width_lp-1:0]   rr_ptr_r;
    logic [addr_width_lp:0]   wr_ptr_r;
    logic [addr_width_lp:0]   rd_ptr_r;
    logic [cnt_width_p-1:0]   cnt_r [num_cnt_lp];
    logic [cnt_width_p-1:0]   drop_cnt_r;
    logic [rec_width_lp-1:0]  mem_r [depth_p];

    logic [num_cnt_lp-1:0]    ev_s;
    logic [channels_p-1:0]    elig_s;
    logic [channels_p-1:0]    active_s;
    logic [7:0]               elig_ev_cnt_s;
    logic                     win_found_s;
    logic [ch_width_lp-1:0]   win_idx_s;
    op_e                      win_op_s;
    logic [paddr_width_p-1:0] win_paddr_s;
    logic [rec_width_lp-1:0]  rec_s;
    logic                     capture_s;
    logic                     wr_en_s;
    logic                     rd_adv_s;
    logic                     buf_drop_s;
    logic [7:0]               drop_inc_s;
    logic                     empty_s;
    logic                     full_s;

    // Flatten events as chan*4+op, decide per-channel eligibility and activity.
    always_comb begin
        ev_s          = {num_cnt_lp{1'b0}};
        elig_s        = {channels_p{1'b0}};
        active_s      = {channels_p{1'b0}};
        elig_ev_cnt_s = 8'd0;
        for (int c = 0; c < channels_p; c++) begin
            ev_s[c*4+0] = access_v_i[c];
            ev_s[c*4+1] = fetch_v_i[c];
            ev_s[c*4+2] = spec_v_i[c];
            ev_s[c*4+3] = req_v_i[c];
`ifdef BP_FE_ICACHE_TRACE_FILTER_EN
            elig_s[c] = (paddr_i[c*paddr_width_p +: paddr_width_p] >= filt_lo_i)
                     && (paddr_i[c*paddr_width_p +: paddr_width_p] <= filt_hi_i);
`else
            elig_s[c] = 1'b1;
`endif
            active_s[c] = elig_s[c] & (access_v_i[c] | fetch_v_i[c] | spec_v_i[c] | req_v_i[c]);
        end
        for (int i = 0; i < num_cnt_lp; i++) begin
            elig_ev_cnt_s = elig_ev_cnt_s + {7'd0, ev_s[i] & elig_s[i/4]};
        end
    end

    // Round-robin pick of the first active channel at or after the RR pointer.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {ch_width_lp{1'b0}};
        for (int k = 0; k < channels_p; k++) begin
            win_idx_s   = (!win_found_s && active_s[(int'(rr_ptr_r) + k) % channels_p])
                        ? ch_width_lp'((int'(rr_ptr_r) + k) % channels_p) : win_idx_s;
            win_found_s = win_found_s | active_s[(int'(rr_ptr_r) + k) % channels_p];
        end
        win_op_s    = spec_v_i[win_idx_s]  ? OP_SPEC  :
                      fetch_v_i[win_idx_s] ? OP_FETCH :
                      req_v_i[win_idx_s]   ? OP_REQ   : OP_ACCESS;
        win_paddr_s = paddr_i[int'(win_idx_s)*paddr_width_p +: paddr_width_p];
        rec_s       = {ts_r, 3'(win_idx_s), win_op_s, win_paddr_s};
    end

    // Buffer write/read-advance decisions and the number of lost events this cycle.
    always_comb begin
        empty_s    = (wr_ptr_r == rd_ptr_r);
        full_s     = (wr_ptr_r[addr_width_lp] != rd_ptr_r[addr_width_lp])
                  && (wr_ptr_r[addr_width_lp-1:0] == rd_ptr_r[addr_width_lp-1:0]);
        capture_s  = en_i & win_found_s;
        wr_en_s    = 1'b0;
        rd_adv_s   = 1'b0;
        buf_drop_s = 1'b0;
        if (capture_s) begin
            if (full_s && !rec_yumi_i) begin
                // No room: either discard the new record or push out the oldest.
                buf_drop_s = 1'b1;
                wr_en_s    = overwrite_i;
                rd_adv_s   = overwrite_i;
            end else begin
                wr_en_s    = 1'b1;
                rd_adv_s   = rec_yumi_i & ~empty_s;
            end
        end else begin
            rd_adv_s = rec_yumi_i & ~empty_s;
        end
        drop_inc_s = capture_s ? (elig_ev_cnt_s - 8'd1 + {7'd0, buf_drop_s}) : 8'd0;
    end

    // Free-running timestamp; wraps naturally.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ts_r <= {ts_width_p{1'b0}};
        else            ts_r <= ts_r + {{(ts_width_p-1){1'b0}}, 1'b1};
    end

    // Buffer pointers and the round-robin pointer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= {(addr_width_lp+1){1'b0}};
            rd_ptr_r <= {(addr_width_lp+1){1'b0}};
            rr_ptr_r <= {ch_width_lp{1'b0}};
        end else begin
            if (wr_en_s)  wr_ptr_r <= wr_ptr_r + {{addr_width_lp{1'b0}}, 1'b1};
            if (rd_adv_s) rd_ptr_r <= rd_ptr_r + {{addr_width_lp{1'b0}}, 1'b1};
            if (capture_s) begin
                rr_ptr_r <= (win_idx_s == ch_width_lp'(channels_p - 1))
                          ? {ch_width_lp{1'b0}} : win_idx_s + {{(ch_width_lp-1){1'b0}}, 1'b1};
            end
        end
    end

    // Record storage; contents are only meaningful between rd and wr pointers.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) mem_r[wr_ptr_r[addr_width_lp-1:0]] <= rec_s;
    end

    // Saturating event counters, counting every asserted bit while enabled.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_cnt_lp; i++) cnt_r[i] <= {cnt_width_p{1'b0}};
        end else if (en_i) begin
            for (int i = 0; i < num_cnt_lp; i++) cnt_r[i] <= sat_add(cnt_r[i], {7'd0, ev_s[i]});
        end
    end

    // Saturating count of events that never reached (or were pushed out of) the buffer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)     drop_cnt_r <= {cnt_width_p{1'b0}};
        else if (capture_s) drop_cnt_r <= sat_add(drop_cnt_r, drop_inc_s);
    end

    // Output view: head record, flags and the selected counter.
    always_comb begin
        rec_v_o    = ~empty_s;
        full_o     = full_s;
        rec_o      = empty_s ? {rec_width_lp{1'b0}} : mem_r[rd_ptr_r[addr_width_lp-1:0]];
        drop_cnt_o = drop_cnt_r;
        if (int'(cnt_sel_i) < num_cnt_lp) cnt_o = cnt_r[cnt_sel_i];
        else                              cnt_o = {cnt_width_p{1'b0}};
    end

    bp_fe_icache_trace_buffer_chk u_chk (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .rec_v_i    (rec_v_o),
        .rec_yumi_i (rec_yumi_i)
    );

endmodule

// File: doc/bp_fe_icache_trace_buffer.md
Name: bp_fe_icache_trace_buffer

Overview:
Synthesizable, parametrised successor to the I$ nonsynth tracer. Monitors up to channels_p I$ instances (access, fetch, spec miss, cache_req) and captures timestamped event records into an on-chip circular buffer, drained via valid/yumi. Keeps per-channel event counters and a drop counter. Sits beside the FE, usable in silicon debug and FPGA, where $fwrite is unavailable.

Parameters:
channels_p, 2, number of monitored I$ channels (1..8)
paddr_width_p, 40, physical address width
depth_p, 16, record buffer entries; power of two, >=2
ts_width_p, 32, timestamp width
cnt_width_p, 32, event and drop counter width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  async active-low reset
en_i  in  1  capture enable
overwrite_i  in  1  1 = overwrite oldest when full; 0 = drop new when full
access_v_i  in  channels_p  I$ access accepted (yumi) per channel
fetch_v_i  in  channels_p  I$ data valid per channel
spec_v_i  in  channels_p  speculative miss per channel
req_v_i  in  channels_p  cache_req handshake (v & yumi) per channel
paddr_i  in  channels_p*paddr_width_p  per-channel paddr_tv_r
rec_o  out  ts_width_p+3+2+paddr_width_p  {ts, chan[2:0], op[1:0], paddr}
rec_v_o  out  1  head record valid
rec_yumi_i  in  1  consume head record
cnt_sel_i  in  clog2(4*channels_p)  counter select = chan*4+op
cnt_o  out  cnt_width_p  selected event counter
drop_cnt_o  out  cnt_width_p  records lost (dropped or overwritten)
full_o  out  1  buffer full

Behaviour:
- Reset (async, reset_n_i low): buffer empty, rec_v_o=0, full_o=0, all counters=0, timestamp=0, RR pointer=0. Release is synchronous to clk_i.
- Opcodes: 0 access, 1 fetch, 2 spec, 3 req. Within a channel, priority is spec > fetch > req > access; a channel is "active" if any input bit is set.
- Event counters: every asserted event bit increments its counter each cycle while en_i=1, independent of buffer state. Counters saturate at all-ones. cnt_o is a combinational mux of the counter array.
- Timestamp: free-running, +1 per cycle, wraps modulo 2^ts_width_p. A record carries the value in its capture cycle.
- Capture: at most one record per cycle. Active channels are round-robin arbitrated starting from the RR pointer; the pointer moves to winner+1 (mod channels_p). Each unrecorded event (other channels, or lower-priority ops on the winner) increments drop_cnt by 1, saturating. With en_i=0, nothing is written or counted.
- Buffer: depth_p entries, wr/rd pointers with an extra wrap bit. Empty = pointers equal; full = equal apart from the wrap bit. Write latency 1: a record captured in cycle N is visible at rec_o in cycle N+1 if the buffer was empty.
- Drain: rec_o/rec_v_o are a registered-pointer head read. rec_yumi_i is legal only when rec_v_o=1, and advances rd pointer on the next edge.
- Full, overwrite_i=0: new record discarded, drop_cnt+1.
- Full, overwrite_i=1: record written, rd pointer advances (oldest lost), drop_cnt+1.
- Full, with yumi and capture in the same cycle: both proceed, occupancy unchanged, no drop.
- Empty, with capture and yumi: yumi is illegal (rec_v_o=0); an assertion fires in simulation.
- Reset mid-drain: all contents discarded.

Optional Feature:
BP_FE_ICACHE_TRACE_FILTER_EN. When defined, adds inputs filt_lo_i and filt_hi_i (paddr_width_p each). Only events with filt_lo_i <= paddr <= filt_hi_i (inclusive, unsigned) are eligible for capture or drop counting; event counters still count all events. When undefined, these ports are absent and all events are eligible.

Test Plan:
- Reset, then en=1, channel 0 fetch at paddr 0x80000040 in cycle 5 -> in cycle 6 rec_v_o=1, rec_o={ts=5, chan=0, op=1, paddr=0x80000040}; yumi -> rec_v_o=0.
- Channels 0 and 1 both access every cycle for 4 cycles -> records alternate chan 0,1,0,1; drop_cnt=4; cnt(0*4+0)=4, cnt(1*4+0)=4.
- Channel 0 with spec and fetch in the same cycle -> one record with op=2; drop_cnt=1; both counters=1.
- overwrite=0, depth 16, 20 events with no drain -> full_o=1, drop_cnt=4, drain yields events 0..15.
- overwrite=1, same stimulus -> drop_cnt=4, drain yields events 4..19 in order.
- Assert reset_n_i low for 1 cycle mid-drain with 8 entries held -> immediately rec_v_o=0, full_o=0, counters=0, timestamp restarts at 0.
